cut_activity_seq: RTL and testbench
===================================

CUT_ACTIVITY_SEQ -- requirements
Module: cut_activity_seq

Interface
REQ-001 Parameter NV_W, default 16: width of the vector-count input.
REQ-002 Parameter CNT_W, default 16: width of each result counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cfg_we  input  1  loads cfg_tt into the truth-table register.
REQ-006 cfg_tt  input  16  4-input cut truth table; bit index = {x3,x2,x1,x0}.
REQ-007 start  input  1  request one profiling run.
REQ-008 abort  input  1  terminate the current run.
REQ-009 mode  input  1  pattern source: 0 = binary up-count, 1 = 4-bit LFSR.
REQ-010 num_vec  input  NV_W  number of vectors to apply in the run.
REQ-011 busy  output  1  high while vectors are being applied.
REQ-012 done  output  1  one-cycle pulse marking the end of a run.
REQ-013 vec  output  4  pattern currently applied to the cut.
REQ-014 f_out  output  1  cut output, tt[vec].
REQ-015 ones_cnt  output  CNT_W  number of vectors with f_out = 1.
REQ-016 tog_cnt  output  CNT_W  number of f_out transitions between consecutive vectors.
REQ-017 in_tog_cnt  output  CNT_W  sum of popcount(vec XOR previous vec).
REQ-018 sat  output  1  sticky flag: a counter saturated during the run.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 IDLE to RUN SHALL occur when start=1 and num_vec≠0.
  - On that edge: clear all counters and sat.
  - Capture num_vec and mode.
  - Load vec = 4'h0 for mode 0, or 4'h1 for mode 1.
REQ-021 In IDLE, start=1 with num_vec=0 SHALL go directly to DONE, leaving all counters at 0.
REQ-022 In RUN, each cycle SHALL evaluate exactly one vector, vec. Per cycle:
  - f_out = tt[vec]; ones_cnt += f_out.
  - From the 2nd vector onward: tog_cnt += (f_out ≠ previous f_out).
  - From the 2nd vector onward: in_tog_cnt += popcount(vec ^ previous vec).
REQ-023 Next vec in mode 0 SHALL be vec+1 mod 16 (wraps 15→0).
REQ-024 Next vec in mode 1 SHALL be a Fibonacci LFSR, x^4+x^3+1, shifting left with feedback = vec[3]^vec[2]. The period is 15, and 0 is never produced.
REQ-025 After the num_vec-th vector is evaluated, the FSM SHALL go RUN→DONE.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 busy SHALL be 1 exactly in RUN, so busy stays high for num_vec cycles.
REQ-028 Counters SHALL saturate at 2^CNT_W−1 and never wrap; sat SHALL be set on any attempted increment beyond that value.
REQ-029 In RUN, abort=1 SHALL return to IDLE on the next edge.
  - done is not pulsed.
  - Counters hold their partial values.
  - If abort and the final vector coincide, abort wins.
REQ-030 start SHALL be ignored in RUN and DONE; there is no queuing.
REQ-031 cfg_we SHALL be honoured only in IDLE; while busy or in DONE it is ignored and tt stays frozen.
REQ-032 If cfg_we and start are asserted in the same IDLE cycle, the new tt SHALL apply to the run being started.
REQ-033 Results SHALL remain stable from DONE until the next accepted start.

Reset
REQ-034 When rst_n=0, the block SHALL immediately enter IDLE with:
  - busy=0, done=0, sat=0, vec=0, f_out=tt[0].
  - All counters 0.
  - tt=16'h9000: output 1 only for {x3,x2,x1,x0} = 1100 and 1111.
REQ-035 rst_n asserted mid-run SHALL discard the run without a done pulse; operation resumes on the first edge after rst_n deasserts.

Verification
REQ-036 The bench SHALL cover these scenarios:
  - Reset tt, mode 0, num_vec=16: busy high for 16 cycles, then done. Expect ones=2, tog=3, in_tog=26, sat=0.
  - Reset tt, mode 0, num_vec=32 (wrap): expect ones=4, tog=7, in_tog=56.
  - cfg_tt=16'hFFFF, mode 1, num_vec=15: expect vec sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8; ones=15, tog=0.
  - CNT_W=4, tt=16'hFFFF, mode 0, num_vec=20: expect ones=15 and sat=1.
  - start with num_vec=0: done pulses on the next cycle, all counters 0, busy never high.
  - abort in the 5th RUN cycle, and separately rst_n pulsed mid-run: both return to IDLE with no done pulse. After the abort, ones_cnt holds its partial value. After the reset, all outputs return to the REQ-034 values.

Source files
------------

// File: rtl/cut_activity_seq.sv
// cut_activity_seq: applies a stream of 4-bit input patterns to a 4-input cut
// (given as a 16-bit truth table) and profiles its switching activity.
// It counts the ones on the output, the output transitions and the input
// bit flips between consecutive vectors. All counters saturate.
module cut_activity_seq #(
  parameter int NV_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [15:0]      cfg_tt,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [NV_W-1:0]  num_vec,
  output logic             busy,
  output logic             done,
  output logic [3:0]       vec,
  output logic             f_out,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic [CNT_W-1:0] in_tog_cnt,
  output logic             sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [15:0]      TT_RESET = 16'h9000;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Saturating add. Bit CNT_W of the result flags an increment that
  // would have gone past the maximum value.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic [2:0]       inc);
    logic [CNT_W+2:0] sum;
    sum = {3'b000, a} + {{CNT_W{1'b0}}, inc};
    if (sum > {3'b000, CNT_MAX}) begin
      return {1'b1, CNT_MAX};
    end
    return {1'b0, sum[CNT_W-1:0]};
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] x);
    return {2'b00, x[0]} + {2'b00, x[1]} + {2'b00, x[2]} + {2'b00, x[3]};
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      tt_q, tt_d;
  logic [3:0]       vec_q, vec_d;
  logic [3:0]       prev_vec_q, prev_vec_d;
  logic             prev_f_q, prev_f_d;
  logic             first_q, first_d;
  logic             mode_q, mode_d;
  logic [NV_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] in_tog_q, in_tog_d;
  logic             sat_q, sat_d;

  logic             f_cur;
  logic [3:0]       vec_next;
  logic [2:0]       tog_inc;
  logic [2:0]       in_tog_inc;
  logic [CNT_W:0]   ones_add;
  logic [CNT_W:0]   tog_add;
  logic [CNT_W:0]   in_tog_add;

  // Per-vector evaluation: cut output, next pattern and saturated counter updates.
  // The first vector of a run has no predecessor and so adds no transitions.
  assign f_cur      = tt_q[vec_q];
  assign vec_next   = mode_q ? {vec_q[2:0], vec_q[3] ^ vec_q[2]} : vec_q + 4'd1;
  assign tog_inc    = first_q ? 3'd0 : {2'b00, f_cur ^ prev_f_q};
  assign in_tog_inc = first_q ? 3'd0 : pop4(vec_q ^ prev_vec_q);
  assign ones_add   = sat_add(ones_q, {2'b00, f_cur});
  assign tog_add    = sat_add(tog_q, tog_inc);
  assign in_tog_add = sat_add(in_tog_q, in_tog_inc);

  // Next-state and datapath control for the IDLE / RUN / DONE sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    tt_d       = tt_q;
    vec_d      = vec_q;
    prev_vec_d = prev_vec_q;
    prev_f_d   = prev_f_q;
    first_d    = first_q;
    mode_d     = mode_q;
    rem_d      = rem_q;
    ones_d     = ones_q;
    tog_d      = tog_q;
    in_tog_d   = in_tog_q;
    sat_d      = sat_q;

    unique case (state_q)
      S_IDLE: begin
        // The table is written on the same edge the run starts, and the
        // first vector is evaluated one cycle later, so a simultaneous
        // cfg_we applies to that run.
        if (cfg_we) begin
          tt_d = cfg_tt;
        end
        if (start) begin
          ones_d   = '0;
          tog_d    = '0;
          in_tog_d = '0;
          sat_d    = 1'b0;
          if (num_vec != '0) begin
            state_d = S_RUN;
            rem_d   = num_vec;
            mode_d  = mode;
            vec_d   = mode ? 4'h1 : 4'h0;
            first_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // Abort discards the vector of the current cycle, including the last one.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          ones_d     = ones_add[CNT_W-1:0];
          tog_d      = tog_add[CNT_W-1:0];
          in_tog_d   = in_tog_add[CNT_W-1:0];
          sat_d      = sat_q | ones_add[CNT_W] | tog_add[CNT_W] | in_tog_add[CNT_W];
          prev_f_d   = f_cur;
          prev_vec_d = vec_q;
          first_d    = 1'b0;
          // vec holds the last evaluated pattern once the run completes.
          if (rem_q == NV_W'(1)) begin
            state_d = S_DONE;
          end else begin
            rem_d = rem_q - NV_W'(1);
            vec_d = vec_next;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tt_q       <= TT_RESET;
      vec_q      <= 4'h0;
      prev_vec_q <= 4'h0;
      prev_f_q   <= 1'b0;
      first_q    <= 1'b1;
      mode_q     <= 1'b0;
      rem_q      <= '0;
      ones_q     <= '0;
      tog_q      <= '0;
      in_tog_q   <= '0;
      sat_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together
      // from values computed before the edge.
      state_q    <= state_d;
      tt_q       <= tt_d;
      vec_q      <= vec_d;
      prev_vec_q <= prev_vec_d;
      prev_f_q   <= prev_f_d;
      first_q    <= first_d;
      mode_q     <= mode_d;
      rem_q      <= rem_d;
      ones_q     <= ones_d;
      tog_q      <= tog_d;
      in_tog_q   <= in_tog_d;
      sat_q      <= sat_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign vec        = vec_q;
  assign f_out      = f_cur;
  assign ones_cnt   = ones_q;
  assign tog_cnt    = tog_q;
  assign in_tog_cnt = in_tog_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_cut_activity_seq.sv
// Testbench for cut_activity_seq: two instances share the stimulus.
// The first instance uses 16-bit counters and the second uses 4-bit counters.
// A behavioural model pushes the expected vectors and results to queues.
// The bench pops them as the DUT presents vectors and finishes runs.
module tb_cut_activity_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_tt = 16'h0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_vec = 16'h0;

  logic        busy_a, done_a, f_a, sat_a;
  logic [3:0]  vec_a;
  logic [15:0] ones_a, tog_a, itog_a;
  logic        busy_b, done_b, f_b, sat_b;
  logic [3:0]  vec_b;
  logic [3:0]  ones_b, tog_b, itog_b;

  cut_activity_seq #(.NV_W(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .start(start),
    .abort(abort), .mode(mode), .num_vec(num_vec), .busy(busy_a), .done(done_a),
    .vec(vec_a), .f_out(f_a), .ones_cnt(ones_a), .tog_cnt(tog_a),
    .in_tog_cnt(itog_a), .sat(sat_a)
  );

  cut_activity_seq #(.NV_W(16), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .start(start),
    .abort(abort), .mode(mode), .num_vec(num_vec), .busy(busy_b), .done(done_b),
    .vec(vec_b), .f_out(f_b), .ones_cnt(ones_b), .tog_cnt(tog_b),
    .in_tog_cnt(itog_b), .sat(sat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ones;  int tog;  int itog;  int sat;
    int ones4; int tog4; int itog4; int sat4;
    int busy_cycles;
    int done_pulse;
  } exp_t;

  exp_t        sb_q[$];
  int          vec_q[$];
  logic [15:0] tt_model = 16'h9000;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Model one run and push its vector sequence and final results.
  task automatic model_run(input bit md, input int nv, input int abort_at);
    exp_t       e;
    logic [3:0] v, pv;
    int         f, pf, ones, tog, itog, n_busy, n_eval;
    n_busy = (abort_at > 0) ? abort_at : nv;
    n_eval = (abort_at > 0) ? abort_at - 1 : nv;
    v = md ? 4'h1 : 4'h0;
    pv = 4'h0; pf = 0; ones = 0; tog = 0; itog = 0;
    for (int i = 0; i < n_busy; i++) begin
      vec_q.push_back(int'(v));
      if (i < n_eval) begin
        f = int'(tt_model[v]);
        ones += f;
        if (i > 0) begin
          tog  += (f != pf) ? 1 : 0;
          itog += $countones(v ^ pv);
        end
        pv = v;
        pf = f;
      end
      v = md ? {v[2:0], v[3] ^ v[2]} : v + 4'd1;
    end
    e.ones  = clamp(ones, 16); e.tog  = clamp(tog, 16); e.itog  = clamp(itog, 16);
    e.sat   = (ones > 65535 || tog > 65535 || itog > 65535) ? 1 : 0;
    e.ones4 = clamp(ones, 4);  e.tog4 = clamp(tog, 4);  e.itog4 = clamp(itog, 4);
    e.sat4  = (ones > 15 || tog > 15 || itog > 15) ? 1 : 0;
    e.busy_cycles = n_busy;
    e.done_pulse  = (abort_at > 0) ? 0 : 1;
    sb_q.push_back(e);
  endtask

  // Launch one run and follow it to done or to the return to idle.
  // While busy, noise drives cfg_we (table 0) and start, and both must be ignored.
  task automatic do_run(input logic [15:0] ttv, input bit load, input bit md,
                        input int nv, input int abort_at, input bit noise);
    exp_t e;
    int   busy_seen, done_seen, ev;
    bit   ended;
    if (load) tt_model = ttv;
    model_run(md, nv, abort_at);
    @(negedge clk);
    cfg_we = load; cfg_tt = ttv; mode = md; num_vec = 16'(nv); start = 1'b1;
    busy_seen = 0; done_seen = 0; ended = 1'b0;
    for (int c = 0; c < 300 && !ended; c++) begin
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0; abort = 1'b0; cfg_tt = 16'h0;
      if (busy_a) begin
        busy_seen++;
        if (vec_q.size() > 0) begin
          ev = vec_q.pop_front();
          check("vec", int'(vec_a), ev);
          check("f_out", int'(f_a), int'(tt_model[ev[3:0]]));
        end else begin
          check("busy_overrun", busy_seen, e.busy_cycles);
        end
        if (busy_seen == abort_at) abort = 1'b1;
        if (noise) begin
          cfg_we = 1'b1;
          start  = 1'b1;
        end
      end else if (done_a) begin
        done_seen = 1;
        ended = 1'b1;
      end else if (busy_seen > 0) begin
        ended = 1'b1;
      end
    end
    if (!ended) check("run_timeout", 0, 1);
    e = sb_q.pop_front();
    check("busy_cycles", busy_seen, e.busy_cycles);
    check("done_pulse", done_seen, e.done_pulse);
    check("ones16", int'(ones_a), e.ones);
    check("tog16", int'(tog_a), e.tog);
    check("in_tog16", int'(itog_a), e.itog);
    check("sat16", int'(sat_a), e.sat);
    check("ones4", int'(ones_b), e.ones4);
    check("tog4", int'(tog_b), e.tog4);
    check("in_tog4", int'(itog_b), e.itog4);
    check("sat4", int'(sat_b), e.sat4);
    check("vec_left", vec_q.size(), 0);
    vec_q.delete();
    // Back in idle: no further done, results unchanged.
    @(negedge clk);
    check("done_after", int'(done_a), 0);
    check("busy_after", int'(busy_a), 0);
    check("ones_hold", int'(ones_a), e.ones);
    check("in_tog_hold", int'(itog_a), e.itog);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, int'(busy_a), 0);
    check({tag, "_done"}, int'(done_a), 0);
    check({tag, "_sat"}, int'(sat_a), 0);
    check({tag, "_vec"}, int'(vec_a), 0);
    check({tag, "_f_out"}, int'(f_a), 0);
    check({tag, "_ones"}, int'(ones_a), 0);
    check({tag, "_tog"}, int'(tog_a), 0);
    check({tag, "_in_tog"}, int'(itog_a), 0);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset table, binary count over 16 and 32 (wrapping) vectors.
    do_run(16'h0000, 1'b0, 1'b0, 16, 0, 1'b0);
    do_run(16'h0000, 1'b0, 1'b0, 32, 0, 1'b0);
    // All-ones table, LFSR, with ignored start/cfg_we during the run.
    do_run(16'hFFFF, 1'b1, 1'b1, 15, 0, 1'b1);
    // Saturation of the 4-bit counters.
    do_run(16'hFFFF, 1'b1, 1'b0, 20, 0, 1'b0);
    // Zero-length run: straight to done, counters cleared.
    do_run(16'hFFFF, 1'b1, 1'b0, 0, 0, 1'b0);
    // Abort in the 5th busy cycle: four vectors counted, no done.
    do_run(16'hFFFF, 1'b1, 1'b0, 10, 5, 1'b0);
    // Table change with start in the same cycle, LFSR over a wrap.
    do_run(16'h5A3C, 1'b1, 1'b1, 20, 0, 1'b0);

    // Reset in the middle of a run.
    @(negedge clk);
    cfg_we = 1'b1; cfg_tt = 16'hFFFF; mode = 1'b0; num_vec = 16'd16; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", int'(busy_a), 1);
    rst_n = 1'b0;
    tt_model = 16'h9000;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", int'(done_a), 0);
    end
    // Reset restored the default table.
    do_run(16'h0000, 1'b0, 1'b0, 16, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
